// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled LSB-first UART receiver with parity and framing error flags.
// Word is presented one clock after the mid-stop sample; no backpressure, o_valid is a one-cycle pulse.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_baud_x16,
  output logic                  o_baud_x16_en,
  input  logic                  i_RX,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_frame_err,
  output logic                  o_parity_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic                    rx_s1_q, rx_s2_q, rx_prev_q;
  logic [3:0]              tick_cnt_q, tick_cnt_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_err_q, par_err_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    valid_q, valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    parity_err_q, parity_err_d;
  logic                    fall;

  // Synchronizer resets high so a line idling high never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= i_RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    dout_d       = dout_q;
    valid_d      = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    case (state_q)
      IDLE: begin
        tick_cnt_d = 4'd0;
        bit_cnt_d  = 4'd0;
        par_err_d  = 1'b0;
        if (fall) state_d = START;
      end
      START: begin
        if (i_baud_x16) begin
          if (tick_cnt_q == 4'd7) begin
            // Mid start bit: a high line here means the edge was a glitch.
            if (!rx_s2_q) begin
              tick_cnt_d = 4'd0;
              state_d    = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (i_baud_x16) begin
          if (tick_cnt_q == 4'd15) begin
            shift_d    = {rx_s2_q, shift_q[DATA_WIDTH-1:1]};
            tick_cnt_d = 4'd0;
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (i_baud_x16) begin
          if (tick_cnt_q == 4'd15) begin
            par_err_d  = (^shift_q) ^ rx_s2_q ^ PARITY_ODD;
            tick_cnt_d = 4'd0;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (i_baud_x16) begin
          if (tick_cnt_q == 4'd15) begin
            // Leave at mid-stop so a following start edge is not missed.
            state_d      = IDLE;
            valid_d      = 1'b1;
            dout_d       = shift_q;
            frame_err_d  = ~rx_s2_q;
            parity_err_d = par_err_q;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_baud_x16_en = (state_q != IDLE);
  assign o_busy        = (state_q != IDLE);
  assign o_dout        = dout_q;
  assign o_valid       = valid_q;
  assign o_frame_err   = frame_err_q;
  assign o_parity_err  = parity_err_q;

endmodule
